micro_sequencer: RTL

- Next-address controller for the 4-bit microprogram counter of the microprogrammed CPU control unit.
- Each cycle it takes the sequencing field of the current micro-instruction, the ALU flags, the opcode and the memory handshake, and selects the next mpc from these sources:
  - incremented mpc
  - branch target
  - opcode dispatch table
  - 2-entry micro-return stack
  - restart address
- Sits between the micro-ROM output register and the micro-ROM address input.

---
 rtl/micro_pkg.sv | 63 ++++++
 rtl/micro_sequencer_if.sv | 37 +++
 rtl/mpc_inc.sv | 12 +
 rtl/micro_sequencer.sv | 121 ++++++++++++
 4 files changed

// File: rtl/micro_pkg.sv
// Shared constants for the micro-sequencer:
// useq codes, flag selects, dispatch table.
package micro_pkg;

  localparam int MPC_W       = 4;
  localparam int OP_W        = 6;
  localparam int STACK_DEPTH = 2;

  typedef enum logic [2:0] {
    SEQ   = 3'd0,
    JMP   = 3'd1,
    BRC   = 3'd2,
    DISP  = 3'd3,
    CALL  = 3'd4,
    RET   = 3'd5,
    WAITM = 3'd6,
    FETCH = 3'd7
  } useq_e;

  localparam logic [1:0] CS_ZERO  = 2'd0;
  localparam logic [1:0] CS_NEG   = 2'd1;
  localparam logic [1:0] CS_CARRY = 2'd2;
  localparam logic [1:0] CS_OVF   = 2'd3;

  localparam logic [OP_W-1:0] OP_ALU = 6'b000000;
  localparam logic [OP_W-1:0] OP_LW  = 6'b100011;
  localparam logic [OP_W-1:0] OP_SW  = 6'b101011;
  localparam logic [OP_W-1:0] OP_BEQ = 6'b000100;
  localparam logic [OP_W-1:0] OP_J   = 6'b000010;

  localparam logic [MPC_W-1:0] A_ALU = 4'd4;
  localparam logic [MPC_W-1:0] A_LW  = 4'd6;
  localparam logic [MPC_W-1:0] A_SW  = 4'd9;
  localparam logic [MPC_W-1:0] A_BEQ = 4'd12;
  localparam logic [MPC_W-1:0] A_J   = 4'd14;

  localparam logic [MPC_W-1:0] RESTART_ADDR = 4'd0;
  localparam logic [MPC_W-1:0] TRAP_ADDR    = 4'd15;

  typedef struct packed {
    logic             illegal;
    logic [MPC_W-1:0] addr;
  } disp_t;

  // Unlisted opcodes land on the trap routine.
  function automatic disp_t dispatch(
    input logic [OP_W-1:0] op
  );
    disp_t d;
    d.illegal = 1'b0;
    d.addr    = TRAP_ADDR;
    case (op)
      OP_ALU:  d.addr = A_ALU;
      OP_LW:   d.addr = A_LW;
      OP_SW:   d.addr = A_SW;
      OP_BEQ:  d.addr = A_BEQ;
      OP_J:    d.addr = A_J;
      default: d.illegal = 1'b1;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/micro_sequencer_if.sv
// Control-unit side bus of the sequencer:
// sequencing inputs and mpc/status outputs.
interface micro_sequencer_if;
  import micro_pkg::*;

  logic             hold;
  logic [2:0]       useq;
  logic [MPC_W-1:0] uaddr;
  logic [1:0]       cond_sel;
  logic [3:0]       flags;
  logic [OP_W-1:0]  opcode;
  logic             instr_valid;
  logic             mem_ready;
  logic [MPC_W-1:0] mpc;
  logic             waiting;
  logic [1:0]       stack_depth;
  logic             err_ovf;
  logic             err_unf;
  logic             illegal_op;

  modport master (
    output hold, useq, uaddr, cond_sel,
    output flags, opcode, instr_valid,
    output mem_ready,
    input  mpc, waiting, stack_depth,
    input  err_ovf, err_unf, illegal_op
  );

  modport slave (
    input  hold, useq, uaddr, cond_sel,
    input  flags, opcode, instr_valid,
    input  mem_ready,
    output mpc, waiting, stack_depth,
    output err_ovf, err_unf, illegal_op
  );

endinterface

// File: rtl/mpc_inc.sv
// Modulo-2^W incrementer for the
// microprogram counter.
module mpc_inc #(
  parameter int W = 4
) (
  input  logic [W-1:0] i_a,
  output logic [W-1:0] o_y
);

  assign o_y = i_a + W'(1);

endmodule

// File: rtl/micro_sequencer.sv
// Next-address controller for the micro-PC:
// increment, branch, dispatch, call/return.
module micro_sequencer
  import micro_pkg::*;
(
  input logic             clk,
  input logic             rst,
  micro_sequencer_if.slave bus
);

  logic [MPC_W-1:0] r_mpc;
  logic [MPC_W-1:0] r_stk [STACK_DEPTH];
  logic [1:0]       r_depth;
  logic             r_ovf;
  logic             r_unf;
  logic             r_ill;

  logic [MPC_W-1:0] w_inc;
  logic [MPC_W-1:0] w_nxt;
  logic             w_push;
  logic             w_pop;
  logic             w_set_ovf;
  logic             w_set_unf;
  logic             w_set_ill;
  logic             w_wait;
  logic             w_full;
  logic             w_empty;
  disp_t            w_disp;

  mpc_inc #(.W(MPC_W)) u_inc (
    .i_a (r_mpc),
    .o_y (w_inc)
  );

  assign w_disp  = dispatch(bus.opcode);
  assign w_full  = (r_depth == 2'(STACK_DEPTH));
  assign w_empty = (r_depth == 2'd0);

  // Select next address and stack/error side effects.
  always_comb begin
    w_nxt     = r_mpc;
    w_push    = 1'b0;
    w_pop     = 1'b0;
    w_set_ovf = 1'b0;
    w_set_unf = 1'b0;
    w_set_ill = 1'b0;
    w_wait    = 1'b0;
    unique case (useq_e'(bus.useq))
      SEQ: w_nxt = w_inc;
      JMP: w_nxt = bus.uaddr;
      BRC: begin
        w_nxt = bus.flags[bus.cond_sel]
              ? bus.uaddr : w_inc;
      end
      DISP: begin
        if (!bus.instr_valid) begin
          w_wait = 1'b1;
        end else begin
          w_nxt     = w_disp.addr;
          w_set_ill = w_disp.illegal;
        end
      end
      CALL: begin
        w_nxt = bus.uaddr;
        if (w_full) w_set_ovf = 1'b1;
        else        w_push    = 1'b1;
      end
      RET: begin
        if (w_empty) begin
          w_nxt     = RESTART_ADDR;
          w_set_unf = 1'b1;
        end else begin
          w_nxt = r_stk[0];
          w_pop = 1'b1;
        end
      end
      WAITM: begin
        if (!bus.mem_ready) w_wait = 1'b1;
        else                w_nxt  = w_inc;
      end
      FETCH: w_nxt = RESTART_ADDR;
    endcase
  end

  // Register mpc, shift-register stack (entry 0 is top) and sticky errors.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_mpc   <= RESTART_ADDR;
      r_depth <= 2'd0;
      for (int i = 0; i < STACK_DEPTH; i++)
        r_stk[i] <= '0;
      r_ovf   <= 1'b0;
      r_unf   <= 1'b0;
      r_ill   <= 1'b0;
    end else if (!bus.hold) begin
      r_mpc <= w_nxt;
      if (w_push) begin
        r_stk[0] <= w_inc;
        for (int i = 1; i < STACK_DEPTH; i++)
          r_stk[i] <= r_stk[i-1];
        r_depth <= r_depth + 2'd1;
      end else if (w_pop) begin
        for (int i = 0; i < STACK_DEPTH-1; i++)
          r_stk[i] <= r_stk[i+1];
        r_stk[STACK_DEPTH-1] <= '0;
        r_depth <= r_depth - 2'd1;
      end
      if (w_set_ovf) r_ovf <= 1'b1;
      if (w_set_unf) r_unf <= 1'b1;
      if (w_set_ill) r_ill <= 1'b1;
    end
  end

  assign bus.mpc         = r_mpc;
  assign bus.waiting     = w_wait;
  assign bus.stack_depth = r_depth;
  assign bus.err_ovf     = r_ovf;
  assign bus.err_unf     = r_unf;
  assign bus.illegal_op  = r_ill;

endmodule
